// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_mem_ctrl: RV32 load/store initiator with RMW sub-word stores |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_merged;

  logic        w_idle;
  logic        w_accept;
  logic [1:0]  w_off;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_err;
  logic        w_word_store;
  logic        w_sub_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // Byte-address bits above the memory window are intentionally ignored.
  wire w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = rst_n & w_idle;
  assign w_accept  = req_valid & req_ready;
  assign w_off     = req_addr[1:0];

  assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (w_off != 2'b00));
  assign w_err      = w_illegal | w_misalign;

  assign w_word_store = req_we & (req_funct3 == 3'b010);
  assign w_sub_store  = req_we & ~req_funct3[1];

  always_comb begin
    w_byte = mem_rd[7:0];
    case (w_off)
      2'd0:    w_byte = mem_rd[7:0];
      2'd1:    w_byte = mem_rd[15:8];
      2'd2:    w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    w_half = w_off[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (req_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rd;
    endcase
  end

  always_comb begin
    w_merged = mem_rd;
    if (req_funct3[0]) begin
      if (w_off[1]) w_merged[31:16] = req_wdata[15:0];
      else          w_merged[15:0]  = req_wdata[15:0];
    end else begin
      case (w_off)
        2'd0:    w_merged[7:0]   = req_wdata[7:0];
        2'd1:    w_merged[15:8]  = req_wdata[7:0];
        2'd2:    w_merged[23:16] = req_wdata[7:0];
        default: w_merged[31:24] = req_wdata[7:0];
      endcase
    end
  end

  // Reset gates the write strobe directly so an in-flight RMW write is dropped.
  assign mem_addr = w_idle ? req_addr[ADDR_W+1:2] : r_addr;
  assign mem_we   = rst_n & (~w_idle | (w_accept & w_word_store & ~w_err));
  assign mem_wd   = mem_we ? (w_idle ? req_wdata : r_merged) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_merged   <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (w_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (w_sub_store) begin
            r_addr   <= req_addr[ADDR_W+1:2];
            r_merged <= w_merged;
            r_state  <= S_RMW_WR;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= req_we ? 32'd0 : w_load;
          end
        end
      end else begin
        r_state    <= S_IDLE;
        resp_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_mem_ctrl: vector table + response scoreboard for the LSU  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;
  sb_t sbq[$];
  sb_t e_mon;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_we;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total_cnt++;
        $display("FAIL resp_unexpected: got resp_valid=1 rdata=%h expected no response", resp_rdata);
      end else begin
        e_mon = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e_mon.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e_mon.err});
        chk("resp_cycle", cyc, e_mon.cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input logic exp_we,
                        input logic push);
    logic acc;
    acc = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      chk("accept_timeout", {31'd0, acc}, 32'd1);
    end else begin
      if (push) sbq.push_back('{exp_rdata, exp_err, cyc + lat});
      chk("mem_addr", 32'(mem_addr), {20'd0, addr[ADDR_W+1:2]});
      chk("mem_we_accept", {31'd0, mem_we}, {31'd0, exp_we});
      chk("mem_wd_accept", mem_wd, exp_we ? wdata : 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int c0;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'hCAFEF00D;
    mem[3] = 32'h8899AABB;

    vecs[0]  = '{1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b100, 32'h0D, 32'h0, 32'h000000AA, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b101, 32'h0E, 32'h0, 32'h00008899, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899AABB, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 32'h0F, 32'h0, 32'hFFFFFF88, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 32'h0C, 32'h0, 32'h0000AABB, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFFFFBB, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 32'h0B, 32'h1234, 32'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'b011, 32'h0C, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 3'b100, 32'h0C, 32'hFF, 32'h0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 3'b110, 32'h0C, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 3'b101, 32'h0C, 32'h5555, 32'h0, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table: loads, errors, SW followed by dependent LW.
    for (int i = 0; i < 16; i++)
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 1, vecs[i].exp_we, 1'b1);
    req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("err_mem2_kept", mem[2], 32'hCAFEF00D);
    chk("err_mem3_kept", mem[3], 32'h8899AABB);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);

    // SB into lane 2 via read-modify-write.
    do_req(1'b1, 3'b000, 32'h0E, 32'h12345655, 32'h0, 1'b0, 2, 1'b0, 1'b1);
    req_valid = 1'b0;
    chk("rmw_ready", {31'd0, req_ready}, 32'd0);
    chk("rmw_we", {31'd0, mem_we}, 32'd1);
    chk("rmw_addr", 32'(mem_addr), 32'd3);
    chk("rmw_wd", mem_wd, 32'h8855AABB);
    @(posedge clk); #1;
    chk("rmw_mem3", mem[3], 32'h8855AABB);
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8855AABB, 1'b0, 1, 1'b0, 1'b1);
    req_valid = 1'b0;

    // Reset asserted during RMW_WR drops the write.
    do_req(1'b1, 3'b001, 32'h0C, 32'h0000CAFE, 32'h0, 1'b0, 2, 1'b0, 1'b0);
    req_valid = 1'b0;
    chk("rstrmw_we_pre", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstrmw_we", {31'd0, mem_we}, 32'd0);
    chk("rstrmw_wd", mem_wd, 32'd0);
    chk("rstrmw_ready", {31'd0, req_ready}, 32'd0);
    chk("rstrmw_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rstrmw_mem3", mem[3], 32'h8855AABB);
    chk("rstrmw_resp2", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rstrmw_ready_after", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8855AABB, 1'b0, 1, 1'b0, 1'b1);
    req_valid = 1'b0;

    // req_valid held: SB @0 then LW @4 must wait out RMW_WR.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h000000A5;
    @(negedge clk);
    chk("hold_sb_ready", {31'd0, req_ready}, 32'd1);
    c0 = cyc;
    sbq.push_back('{32'h0, 1'b0, c0 + 2});
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h0;
    @(negedge clk);
    chk("hold_lw_blocked", {31'd0, req_ready}, 32'd0);
    chk("hold_rmw_wd", mem_wd, 32'h112233A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_lw_ready", {31'd0, req_ready}, 32'd1);
    chk("hold_lw_cycle", cyc, c0 + 2);
    sbq.push_back('{32'h55667788, 1'b0, c0 + 3});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h112233A5, 1'b0, 1, 1'b0, 1'b1);
    req_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
